// File: rtl/cycle_cnt_sync.sv
// Ultrasound phase counter and modulation index, aligned to a host-supplied absolute sync time.
// Optional feature: define CYCLE_CNT_SYNC_LATE_ALIGN_EN to align late targets instead of rejecting them.
module cycle_cnt_sync #(
  parameter int CYCLE_WIDTH   = 9,
  parameter int MOD_IDX_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              sys_time,
  input  logic                     sync_req,
  input  logic [63:0]              sync_time,
  input  logic [15:0]              mod_div,
  input  logic [MOD_IDX_WIDTH-1:0] mod_cycle,
  output logic                     sync_ack,
  output logic [CYCLE_WIDTH-1:0]   cycle_cnt,
  output logic                     cycle_start,
  output logic [MOD_IDX_WIDTH-1:0] mod_idx,
  output logic                     synced,
  output logic                     time_err
);

  typedef enum logic [1:0] {ST_UNSYNC, ST_ARMED, ST_RUN} state_t;

  state_t                   state_reg, state_next;
  logic [CYCLE_WIDTH-1:0]   cycle_cnt_reg, cycle_cnt_next;
  logic                     cycle_start_reg, cycle_start_next;
  logic [MOD_IDX_WIDTH-1:0] mod_idx_reg, mod_idx_next;
  logic [15:0]              div_reg, div_next;
  logic                     synced_reg, synced_next;
  logic                     time_err_reg, time_err_next;
  logic                     sync_ack_reg, sync_ack_next;
  logic [63:0]              target_reg, target_next;
  logic [63:0]              prev_time_reg;
  logic                     prev_valid_reg;
  logic                     req_block_reg, req_block_next;

  logic                     disc;
  logic                     accept;
  logic                     late;
  logic                     wrap;
  logic [15:0]              mod_div_m1;
  logic [MOD_IDX_WIDTH-1:0] mod_cycle_m1;

  assign disc   = prev_valid_reg && (sys_time != prev_time_reg + 64'd1);
  assign accept = sync_req && !req_block_reg && (state_reg != ST_ARMED);
  assign late   = !(sync_time > sys_time);
  assign wrap   = (cycle_cnt_reg == '1);

  // A zero divider or loop length behaves like one.
  assign mod_div_m1   = (mod_div == 16'd0) ? 16'd0 : mod_div - 16'd1;
  assign mod_cycle_m1 = (mod_cycle == '0) ? '0 : mod_cycle - MOD_IDX_WIDTH'(1);

  always_comb begin
    state_next     = state_reg;
    cycle_cnt_next = cycle_cnt_reg + CYCLE_WIDTH'(1);
    mod_idx_next   = mod_idx_reg;
    div_next       = div_reg;
    synced_next    = synced_reg;
    time_err_next  = time_err_reg;
    sync_ack_next  = 1'b0;
    target_next    = target_reg;
    req_block_next = req_block_reg && sync_req;

    // Modulation advances only while locked, including while re-armed from RUN.
    if (synced_reg && wrap) begin
      if (div_reg >= mod_div_m1) begin
        div_next     = 16'd0;
        mod_idx_next = (mod_idx_reg >= mod_cycle_m1) ? '0 : mod_idx_reg + MOD_IDX_WIDTH'(1);
      end else begin
        div_next = div_reg + 16'd1;
      end
    end

    if (accept) begin
      sync_ack_next  = 1'b1;
      req_block_next = 1'b1;
    end

    if (disc) begin
      time_err_next = 1'b1;
      synced_next   = 1'b0;
      state_next    = ST_UNSYNC;
      mod_idx_next  = '0;
      div_next      = 16'd0;
    end else if (state_reg == ST_ARMED && sys_time == target_reg) begin
      cycle_cnt_next = '0;
      mod_idx_next   = '0;
      div_next       = 16'd0;
      synced_next    = 1'b1;
      state_next     = ST_RUN;
    end else if (accept) begin
      time_err_next = 1'b0;
      target_next   = sync_time;
      if (!late) begin
        state_next = ST_ARMED;
      end else begin
`ifdef CYCLE_CNT_SYNC_LATE_ALIGN_EN
        cycle_cnt_next = CYCLE_WIDTH'(sys_time - sync_time + 64'd1);
        mod_idx_next   = '0;
        div_next       = 16'd0;
        synced_next    = 1'b1;
        state_next     = ST_RUN;
`else
        time_err_next = 1'b1;
`endif
      end
    end

    cycle_start_next = (cycle_cnt_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_UNSYNC;
      cycle_cnt_reg   <= '0;
      cycle_start_reg <= 1'b0;
      mod_idx_reg     <= '0;
      div_reg         <= 16'd0;
      synced_reg      <= 1'b0;
      time_err_reg    <= 1'b0;
      sync_ack_reg    <= 1'b0;
      target_reg      <= 64'd0;
      prev_time_reg   <= 64'd0;
      prev_valid_reg  <= 1'b0;
      req_block_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cycle_cnt_reg   <= cycle_cnt_next;
      cycle_start_reg <= cycle_start_next;
      mod_idx_reg     <= mod_idx_next;
      div_reg         <= div_next;
      synced_reg      <= synced_next;
      time_err_reg    <= time_err_next;
      sync_ack_reg    <= sync_ack_next;
      target_reg      <= target_next;
      prev_time_reg   <= sys_time;
      prev_valid_reg  <= 1'b1;
      req_block_reg   <= req_block_next;
    end
  end

  assign sync_ack    = sync_ack_reg;
  assign cycle_cnt   = cycle_cnt_reg;
  assign cycle_start = cycle_start_reg;
  assign mod_idx     = mod_idx_reg;
  assign synced      = synced_reg;
  assign time_err    = time_err_reg;

endmodule

// File: tb/tb_cycle_cnt_sync.sv
// Directed bench for cycle_cnt_sync: table-driven counter/modulation checks plus sync corner sequences.
module tb_cycle_cnt_sync;

  logic        clk;
  logic        rst_n;
  logic [63:0] sys_time;
  logic        sync_req;
  logic [63:0] sync_time;
  logic [15:0] mod_div;
  logic [11:0] mod_cycle;
  logic        sync_ack;
  logic [8:0]  cycle_cnt;
  logic        cycle_start;
  logic [11:0] mod_idx;
  logic        synced;
  logic        time_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          n_adv;
    logic [11:0] mcyc;
    logic [8:0]  cnt;
    logic        start;
    logic        syn;
    logic [11:0] mod;
  } vec_t;

  vec_t tab1 [4];
  vec_t tab3 [7];

  cycle_cnt_sync #(.CYCLE_WIDTH(9), .MOD_IDX_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .sys_time(sys_time), .sync_req(sync_req),
    .sync_time(sync_time), .mod_div(mod_div), .mod_cycle(mod_cycle),
    .sync_ack(sync_ack), .cycle_cnt(cycle_cnt), .cycle_start(cycle_start),
    .mod_idx(mod_idx), .synced(synced), .time_err(time_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: DUT samples current sys_time, then time advances by one.
  task automatic adv();
    @(posedge clk);
    #1;
    sys_time = sys_time + 64'd1;
  endtask

  task automatic adv_until(input logic [63:0] t);
    for (int g = 0; g < 4000 && sys_time != t; g++) adv();
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    mod_cycle = v.mcyc;
    for (int i = 0; i < v.n_adv; i++) adv();
    chk({tag, " cnt"},    cycle_cnt,   v.cnt);
    chk({tag, " start"},  cycle_start, v.start);
    chk({tag, " synced"}, synced,      v.syn);
    chk({tag, " mod"},    mod_idx,     v.mod);
  endtask

  initial begin
    logic [63:0] tgt;
    logic [8:0]  k;
    logic        late_align;
`ifdef CYCLE_CNT_SYNC_LATE_ALIGN_EN
    late_align = 1'b1;
`else
    late_align = 1'b0;
`endif

    tab1[0] = '{1,   12'd1, 9'd1,   1'b0, 1'b0, 12'd0};
    tab1[1] = '{510, 12'd1, 9'd511, 1'b0, 1'b0, 12'd0};
    tab1[2] = '{1,   12'd1, 9'd0,   1'b1, 1'b0, 12'd0};
    tab1[3] = '{1,   12'd1, 9'd1,   1'b0, 1'b0, 12'd0};

    tab3[0] = '{511,  12'd3, 9'd511, 1'b0, 1'b1, 12'd0};
    tab3[1] = '{1,    12'd3, 9'd0,   1'b1, 1'b1, 12'd1};
    tab3[2] = '{1023, 12'd3, 9'd511, 1'b0, 1'b1, 12'd1};
    tab3[3] = '{1,    12'd3, 9'd0,   1'b1, 1'b1, 12'd2};
    tab3[4] = '{1023, 12'd1, 9'd511, 1'b0, 1'b1, 12'd2};
    tab3[5] = '{1,    12'd1, 9'd0,   1'b1, 1'b1, 12'd0};
    tab3[6] = '{2048, 12'd1, 9'd0,   1'b1, 1'b1, 12'd0};

    rst_n = 1'b0; sys_time = 64'd0; sync_req = 1'b0; sync_time = 64'd0;
    mod_div = 16'd1; mod_cycle = 12'd1;

    // Reset held with a jumping time base: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      adv();
      sys_time = {$urandom, $urandom};
      chk("rst cnt",   cycle_cnt,   0);
      chk("rst start", cycle_start, 0);
      chk("rst synced", synced,     0);
      chk("rst err",   time_err,    0);
      chk("rst ack",   sync_ack,    0);
      chk("rst mod",   mod_idx,     0);
    end
    sys_time = 64'd100;
    rst_n = 1'b1;
    foreach (tab1[i]) run_vec($sformatf("free%0d", i), tab1[i]);
    chk("first sample err", time_err, 0);

    // Future sync target; request stays high throughout.
    mod_div = 16'd2; mod_cycle = 12'd3;
    adv_until(64'd1000);
    sync_req = 1'b1; sync_time = 64'd1500;
    adv();
    chk("sync ack", sync_ack, 1);
    adv();
    chk("ack pulse", sync_ack, 0);
    adv_until(64'd1500);
    chk("armed synced", synced, 0);
    adv();
    chk("match cnt",    cycle_cnt,   0);
    chk("match start",  cycle_start, 1);
    chk("match synced", synced,      1);
    chk("match mod",    mod_idx,     0);
    chk("held req ack", sync_ack,    0);
    for (int i = 0; i < 511; i++) adv();
    chk("period cnt",   cycle_cnt,   511);
    chk("period start", cycle_start, 0);
    adv();
    chk("period2 start", cycle_start, 1);
    chk("held req ack2", sync_ack,    0);
    sync_req = 1'b0;

    foreach (tab3[i]) run_vec($sformatf("mod%0d", i), tab3[i]);

    // Late targets: equal to current time, then ten clocks in the past.
    sync_req = 1'b1; sync_time = sys_time;
    adv();
    chk("late0 ack",    sync_ack,  1);
    chk("late0 cnt",    cycle_cnt, 1);
    chk("late0 synced", synced,    1);
    chk("late0 err",    time_err,  late_align ? 0 : 1);
    sync_req = 1'b0;
    adv();
    chk("late0 ack off", sync_ack, 0);
    sync_req = 1'b1; sync_time = sys_time - 64'd10;
    adv();
    chk("late10 ack",    sync_ack,  1);
    chk("late10 cnt",    cycle_cnt, late_align ? 11 : 3);
    chk("late10 synced", synced,    1);
    chk("late10 err",    time_err,  late_align ? 0 : 1);
    chk("late10 mod",    mod_idx,   0);
    sync_req = 1'b0;
    adv();

    // Re-sync from RUN clears any error, then locks at the new target.
    sync_req = 1'b1; tgt = sys_time + 64'd100; sync_time = tgt;
    adv();
    chk("resync ack", sync_ack, 1);
    chk("resync err", time_err, 0);
    sync_req = 1'b0;
    adv_until(tgt);
    adv();
    chk("resync cnt",    cycle_cnt,   0);
    chk("resync start",  cycle_start, 1);
    chk("resync synced", synced,      1);
    adv();
    chk("pre jump err", time_err, 0);

    // Forward jump of the time base.
    sys_time = sys_time + 64'd999;
    adv();
    chk("jump err",    time_err, 1);
    chk("jump synced", synced,   0);
    chk("jump mod",    mod_idx,  0);

    // A jump while armed aborts the pending target.
    sync_req = 1'b1; tgt = sys_time + 64'd50; sync_time = tgt;
    adv();
    chk("arm2 ack", sync_ack, 1);
    chk("arm2 err", time_err, 0);
    sync_req = 1'b0;
    adv();
    sys_time = sys_time + 64'd5;
    adv();
    chk("abort err", time_err, 1);
    adv_until(tgt + 64'd3);
    chk("abort synced", synced, 0);

    // Roll-over of the 64-bit time base is continuous.
    sys_time = 64'hFFFF_FFFF_FFFF_FFF0;
    adv();
    sync_req = 1'b1; sync_time = 64'hFFFF_FFFF_FFFF_FFFA;
    adv();
    chk("roll ack", sync_ack, 1);
    chk("roll err", time_err, 0);
    sync_req = 1'b0;
    adv_until(64'hFFFF_FFFF_FFFF_FFFA);
    adv();
    chk("roll lock", synced, 1);
    for (int i = 0; i < 10; i++) adv();
    chk("roll over err",    time_err,  0);
    chk("roll over synced", synced,    1);
    chk("roll over cnt",    cycle_cnt, 10);

    // Asynchronous reset while armed discards the target.
    sync_req = 1'b1; tgt = sys_time + 64'd1000; sync_time = tgt;
    adv();
    chk("arm3 ack", sync_ack, 1);
    sync_req = 1'b0;
    for (int i = 0; i < 5; i++) adv();
    rst_n = 1'b0;
    #2;
    chk("async rst cnt",    cycle_cnt,   0);
    chk("async rst start",  cycle_start, 0);
    chk("async rst synced", synced,      0);
    chk("async rst err",    time_err,    0);
    chk("async rst mod",    mod_idx,     0);
    #2;
    rst_n = 1'b1;
    k = 9'd0;
    for (int g = 0; g < 2000 && sys_time != tgt + 64'd5; g++) begin
      adv();
      k = k + 9'd1;
    end
    chk("post rst synced", synced,    0);
    chk("post rst err",    time_err,  0);
    chk("post rst cnt",    cycle_cnt, k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
